alu_mc: RTL

- Parametrised multi-cycle ALU; successor to the 8-bit single-cycle ALU in the datapath.
- Adds generic width, a valid/ready operand and result handshake, iterative unsigned multiply and divide, arithmetic shift right, and overflow and divide-by-zero flags.
- Sits between the register file and write-back; the sequencer stalls on in_ready/out_valid instead of assuming fixed 1-cycle latency.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_mc_if.sv | 31 +++
 rtl/alu_muldiv.sv | 87 ++++++++
 rtl/alu_mc.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU.
// Contents: opcode bit indices, flag bit indices, the FSM state enum, and a
// helper that tells a legal one-hot opcode from an illegal one.
package alu_pkg;

   localparam int OP_W   = 10;

   localparam int OP_ADD = 0;
   localparam int OP_SUB = 1;
   localparam int OP_AND = 2;
   localparam int OP_OR  = 3;
   localparam int OP_NOT = 4;
   localparam int OP_SHL = 5;
   localparam int OP_SHR = 6;
   localparam int OP_ASR = 7;
   localparam int OP_MUL = 8;
   localparam int OP_DIV = 9;

   localparam int FL_C   = 0;
   localparam int FL_Z   = 1;
   localparam int FL_P   = 2;
   localparam int FL_V   = 3;
   localparam int FL_DZ  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Exactly one bit set: x & (x-1) clears the lowest set bit.
   function automatic logic op_is_legal(input logic [OP_W-1:0] op);
      return (op != '0) && ((op & (op - OP_W'(1))) == '0);
   endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result bus of the multi-cycle ALU.
// master: the sequencer (drives in_valid, a, b, fi, op, out_ready)
// slave : the ALU      (drives in_ready, out_valid, d, d_hi, fo)
interface alu_mc_if
   import alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int FLAG_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic [FLAG_W-1:0] fi;
   logic [OP_W-1:0]   op;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  d;
   logic [WIDTH-1:0]  d_hi;
   logic [FLAG_W-1:0] fo;

   modport master (
      output in_valid, a, b, fi, op, out_ready,
      input  in_ready, out_valid, d, d_hi, fo
   );

   modport slave (
      input  in_valid, a, b, fi, op, out_ready,
      output in_ready, out_valid, d, d_hi, fo
   );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiplier / restoring divider, one bit per cycle.
// Ports: clk, rst (sync, active-high); start_i loads operands, is_div_i
// selects divide; done_o is high during the last iteration, and lo_o/hi_o
// carry the value produced by the current iteration (final product or
// quotient/remainder when done_o is high).
module alu_muldiv #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             is_div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] hi_o
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d, opnd_q, opnd_d;
   logic             is_div_q, is_div_d;
   logic [WIDTH:0]   add_sum, rem_shift, rem_diff;
   logic [WIDTH-1:0] lo_step, hi_step;

   // MUL: {hi,lo} starts as {0,b}; add a into hi when lo[0] is set, then
   // shift the pair right.  DIV: lo starts as the dividend and shifts left
   // into hi; a non-negative trial subtract keeps the difference and
   // shifts a 1 into the quotient.
   always_comb begin
      add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      rem_shift = {hi_q, lo_q[WIDTH-1]};
      rem_diff  = rem_shift - {1'b0, opnd_q};
      if (is_div_q) begin
         if (rem_diff[WIDTH]) begin
            hi_step = rem_shift[WIDTH-1:0];
            lo_step = {lo_q[WIDTH-2:0], 1'b0};
         end else begin
            hi_step = rem_diff[WIDTH-1:0];
            lo_step = {lo_q[WIDTH-2:0], 1'b1};
         end
      end else begin
         hi_step = add_sum[WIDTH:1];
         lo_step = {add_sum[0], lo_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      cnt_d    = cnt_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      opnd_d   = opnd_q;
      is_div_d = is_div_q;
      if (start_i) begin
         cnt_d    = CNT_W'(WIDTH);
         is_div_d = is_div_i;
         hi_d     = '0;
         lo_d     = is_div_i ? a_i : b_i;
         opnd_d   = is_div_i ? b_i : a_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
         lo_d  = lo_step;
         hi_d  = hi_step;
      end
   end

   assign done_o = (cnt_q == CNT_W'(1));
   assign lo_o   = lo_step;
   assign hi_o   = hi_step;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         lo_q     <= '0;
         hi_q     <= '0;
         opnd_q   <= '0;
         is_div_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         opnd_q   <= opnd_d;
         is_div_q <= is_div_d;
      end
   end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready operand and result handshake.
// Ports: clk, rst (sync, active-high), bus (alu_mc_if.slave): operands
// a/b/fi/op in, d/d_hi/fo out.  Single-cycle ops complete one cycle after
// accept; MUL and DIV (b != 0) take WIDTH+1 cycles via alu_muldiv.
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | in_ready high, waiting for in_valid
// ST_CALC | alu_muldiv iterating, inputs ignored
// ST_DONE | result held on d/d_hi/fo with out_valid high
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int FLAG_W = 8
) (
   input logic     clk,
   input logic     rst,
   alu_mc_if.slave bus
);
   localparam logic [WIDTH-1:0] SH_LIM = WIDTH'(WIDTH);

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  d_q, d_d, d_hi_q, d_hi_d;
   logic [FLAG_W-1:0] fo_q, fo_d, sc_fo;
   logic              is_div_q, is_div_d;

   logic              legal, is_multi, big_amt, cin;
   logic [WIDTH-1:0]  sc_lo, sc_hi;
   logic              sc_c, sc_v, sc_dz;
   logic [WIDTH:0]    shl_ext, shr_ext, asr_ext;

   logic              md_start, md_done;
   logic [WIDTH-1:0]  md_lo, md_hi;

   logic              unused_fi;
   assign unused_fi = ^bus.fi[FLAG_W-1:1];

   function automatic logic [FLAG_W-1:0] mk_flags(input logic [WIDTH-1:0] res,
                                                  input logic c, v, dz);
      logic [FLAG_W-1:0] f;
      f        = '0;
      f[FL_C]  = c;
      f[FL_Z]  = (res == '0);
      f[FL_P]  = !res[WIDTH-1] && (res != '0);
      f[FL_V]  = v;
      f[FL_DZ] = dz;
      return f;
   endfunction

   alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk      (clk),
      .rst      (rst),
      .start_i  (md_start),
      .is_div_i (bus.op[OP_DIV]),
      .a_i      (bus.a),
      .b_i      (bus.b),
      .done_o   (md_done),
      .lo_o     (md_lo),
      .hi_o     (md_hi)
   );

   // Extended shifts: the extra bit catches the last bit shifted out.
   assign shl_ext = {1'b0, bus.a} << bus.b;
   assign shr_ext = {bus.a, 1'b0} >> bus.b;
   assign asr_ext = $signed({bus.a, 1'b0}) >>> bus.b;

   assign legal    = op_is_legal(bus.op);
   assign big_amt  = (bus.b >= SH_LIM);
   assign cin      = bus.fi[0];
   assign is_multi = legal && (bus.op[OP_MUL] || (bus.op[OP_DIV] && bus.b != '0));

   always_comb begin
      sc_lo = '0;
      sc_hi = '0;
      sc_c  = 1'b0;
      sc_v  = 1'b0;
      sc_dz = 1'b0;
      if (legal) begin
         case (1'b1)
            bus.op[OP_ADD]: begin
               {sc_c, sc_lo} = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cin};
               sc_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sc_lo[WIDTH-1] != bus.a[WIDTH-1]);
            end
            bus.op[OP_SUB]: begin
               {sc_c, sc_lo} = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, cin};
               sc_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sc_lo[WIDTH-1] != bus.a[WIDTH-1]);
            end
            bus.op[OP_AND]: sc_lo = bus.a & bus.b;
            bus.op[OP_OR]:  sc_lo = bus.a | bus.b;
            bus.op[OP_NOT]: sc_lo = ~bus.a;
            bus.op[OP_SHL]: if (!big_amt) {sc_c, sc_lo} = shl_ext;
            bus.op[OP_SHR]: if (!big_amt) {sc_lo, sc_c} = shr_ext;
            bus.op[OP_ASR]: begin
               if (big_amt) begin
                  sc_lo = {WIDTH{bus.a[WIDTH-1]}};
                  sc_c  = bus.a[WIDTH-1];
               end else begin
                  {sc_lo, sc_c} = asr_ext;
               end
            end
            // Only reaches the single-cycle path with b == 0.
            bus.op[OP_DIV]: begin
               sc_lo = '1;
               sc_hi = bus.a;
               sc_dz = 1'b1;
            end
            default: ;
         endcase
      end
      sc_fo = mk_flags(sc_lo, sc_c, sc_v, sc_dz);
   end

   always_comb begin
      state_d  = state_q;
      d_d      = d_q;
      d_hi_d   = d_hi_q;
      fo_d     = fo_q;
      is_div_d = is_div_q;
      md_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               if (is_multi) begin
                  state_d  = ST_CALC;
                  md_start = 1'b1;
                  is_div_d = bus.op[OP_DIV];
               end else begin
                  state_d = ST_DONE;
                  d_d     = sc_lo;
                  d_hi_d  = sc_hi;
                  fo_d    = sc_fo;
               end
            end
         end
         ST_CALC: begin
            if (md_done) begin
               state_d = ST_DONE;
               d_d     = md_lo;
               d_hi_d  = md_hi;
               fo_d    = mk_flags(md_lo, !is_div_q && (md_hi != '0), 1'b0, 1'b0);
            end
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         d_q      <= '0;
         d_hi_q   <= '0;
         fo_q     <= '0;
         is_div_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         d_q      <= d_d;
         d_hi_q   <= d_hi_d;
         fo_q     <= fo_d;
         is_div_q <= is_div_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.d         = d_q;
   assign bus.d_hi      = d_hi_q;
   assign bus.fo        = fo_q;
endmodule
